// File: rtl/ram_bus_pkg.sv
// Shared types and default sizes for the RAM bus arbiter slice.
package ram_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int RAM_AW = 4;
  localparam int RAM_DW = 4;

endpackage

// File: rtl/arb_pick2.sv
// Two-way combinational winner select; prio names the requester favoured on a tie.
module arb_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic valid,
  output logic win
);

  always_comb begin
    valid = req0 | req1;
    win   = (req0 & req1) ? prio : req1;
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Two-requester arbiter/sequencer driving the single port of the 16x4 RAM.
// Define ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module ram_bus_arbiter
  import ram_bus_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clk1000,
  input  logic          clr,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic          owner
);

  state_t state;
  logic   lat_we;
  logic   pick_valid;
  logic   pick_win;
  logic   prio;

`ifdef ARB_RR_EN
  logic rr_ptr;
  assign prio = rr_ptr;
`else
  assign prio = 1'b0;
`endif

  arb_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .prio  (prio),
    .valid (pick_valid),
    .win   (pick_win)
  );

  assign busy = (state != IDLE);

  // ram_addr/ram_din double as the latched request fields, so the RAM port
  // is fed straight from registers during ACCESS.
  always_ff @(posedge clk1000) begin
    if (clr) begin
      state    <= IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      ram_wen  <= 1'b0;
      owner    <= 1'b0;
      lat_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      rdata    <= '0;
`ifdef ARB_RR_EN
      rr_ptr   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= ACCESS;
            owner    <= pick_win;
            gnt0     <= ~pick_win;
            gnt1     <= pick_win;
            lat_we   <= pick_win ? we1 : we0;
            ram_wen  <= pick_win ? we1 : we0;
            ram_addr <= pick_win ? addr1 : addr0;
            ram_din  <= pick_win ? wdata1 : wdata0;
`ifdef ARB_RR_EN
            rr_ptr   <= ~pick_win;
`endif
          end
        end
        ACCESS: begin
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          ram_wen <= 1'b0;
          if (lat_we) begin
            state <= IDLE;
          end else begin
            rdata   <= ram_dout;
            rvalid0 <= ~owner;
            rvalid1 <= owner;
            state   <= RESP;
          end
        end
        RESP: begin
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter with a behavioural RAM and transaction-level reference memory.
module tb_ram_bus_arbiter;

  localparam int AW = 4;
  localparam int DW = 4;

  logic          clk1000 = 1'b0;
  logic          clr;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy, owner;

  int checks = 0;
  int failures = 0;
  int unsigned wen_bad = 0;

  logic [DW-1:0] mem     [16];
  logic [DW-1:0] ref_mem [16];

  always #5 clk1000 = ~clk1000;

  ram_bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk1000 (clk1000),
    .clr     (clr),
    .req0    (req0),
    .req1    (req1),
    .we0     (we0),
    .we1     (we1),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1),
    .rdata   (rdata),
    .ram_wen (ram_wen),
    .ram_addr(ram_addr),
    .ram_din (ram_din),
    .ram_dout(ram_dout),
    .busy    (busy),
    .owner   (owner)
  );

  // Behavioural 16x4 RAM: combinational read, write on the clock edge.
  assign ram_dout = mem[ram_addr];
  always @(posedge clk1000) if (ram_wen) mem[ram_addr] <= ram_din;

  // A write enable with no grant showing means a write outside ACCESS.
  always @(negedge clk1000) if (ram_wen && !(gnt0 || gnt1)) wen_bad++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1000);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt0"}, gnt0, 0);
    check({tag, "_gnt1"}, gnt1, 0);
    check({tag, "_rv0"}, rvalid0, 0);
    check({tag, "_rv1"}, rvalid1, 0);
    check({tag, "_wen"}, ram_wen, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // One single-shot access; scramble alters the requester fields during ACCESS.
  task automatic access(input int r, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic scramble);
    if (r == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    tick();
    check("acc_gnt0", gnt0, r == 0);
    check("acc_gnt1", gnt1, r == 1);
    check("acc_wen", ram_wen, we);
    check("acc_addr", ram_addr, a);
    check("acc_busy", busy, 1);
    check("acc_owner", owner, r[0]);
    if (we) check("acc_din", ram_din, d);
    req0 = 0;
    req1 = 0;
    if (scramble) begin
      addr0 = ~a; wdata0 = ~d; addr1 = ~a; wdata1 = ~d; we0 = ~we; we1 = ~we;
    end
    tick();
    if (we) begin
      ref_mem[a] = d;
      check_quiet("wr_done");
    end else begin
      check("rd_rv0", rvalid0, r == 0);
      check("rd_rv1", rvalid1, r == 1);
      check("rd_data", rdata, ref_mem[a]);
      check("rd_busy", busy, 1);
      check("rd_wen", ram_wen, 0);
      tick();
      check_quiet("rd_done");
      check("rd_hold", rdata, ref_mem[a]);
    end
  endtask

  initial begin
    int grants;
    int exp_win;
    for (int i = 0; i < 16; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    clr = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    repeat (3) tick();
    check_quiet("rst");
    check("rst_owner", owner, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_din", ram_din, 0);
    check("rst_rdata", rdata, 0);
    clr = 0;
    repeat (5) tick();
    check_quiet("idle");
    check("idle_owner", owner, 0);

    access(0, 1, 4'd1, 4'd1, 0);
    access(0, 0, 4'd1, 4'd0, 0);
    access(1, 1, 4'd0, 4'd15, 0);
    access(1, 0, 4'd0, 4'd0, 0);
    access(1, 0, 4'd1, 4'd0, 0);
    check("owner_stays1", owner, 1);

    // Continuous contention: both requesters write, held for 8 grants.
    req0 = 1; we0 = 1; addr0 = 4'd2; wdata0 = 4'd5;
    req1 = 1; we1 = 1; addr1 = 4'd3; wdata1 = 4'd6;
    grants = 0;
    for (int cyc = 0; cyc < 40 && grants < 8; cyc++) begin
      tick();
      if (gnt0 | gnt1) begin
`ifdef ARB_RR_EN
        exp_win = grants % 2;
`else
        exp_win = 0;
`endif
        check("contend_win", gnt1, exp_win);
        check("contend_one", gnt0 ^ gnt1, 1);
        if (exp_win == 1) ref_mem[3] = 4'd6; else ref_mem[2] = 4'd5;
        grants++;
        if (grants == 8) begin req0 = 0; req1 = 0; end
      end
    end
    check("contend_count", grants, 8);
    tick();
    check_quiet("contend_end");
    access(0, 0, 4'd2, 4'd0, 0);
    access(1, 0, 4'd3, 4'd0, 0);

    // Inputs changed during ACCESS must not affect the write.
    access(0, 1, 4'd5, 4'd9, 1);
    access(0, 0, 4'd5, 4'd0, 0);
    access(1, 0, 4'd10, 4'd0, 0);

    // Reset during RESP of a read.
    req0 = 1; we0 = 0; addr0 = 4'd1;
    tick();
    req0 = 0;
    tick();
    check("pre_rst_rv0", rvalid0, 1);
    check("pre_rst_rdata", rdata, ref_mem[1]);
    clr = 1;
    tick();
    clr = 0;
    check_quiet("mid_rst");
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_owner", owner, 0);
    tick();
    check_quiet("post_rst");

    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)));
    end

    check("wen_outside_access", wen_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_bus_arbiter.md
# ram_bus_arbiter

Two-requester arbiter and sequencer in front of the 16x4 `RAM` block. It accepts read/write requests from two independent masters (e.g. the switch-input path and a display-refresh path), grants one at a time, and drives the single RAM port with the granted request. It returns read data to the owner with a one-cycle valid pulse. It sits between the requesters and `RAM`, replacing direct `wen/addr/in` wiring.

## Interface
- `AW`, default 4, RAM address width.
- `DW`, default 4, RAM data width.

- `clk1000`  in  1  system clock.
- `clr`  in  1  reset, synchronous, active-high.
- `req0` / `req1`  in  1  access request from requester 0 / 1.
- `we0` / `we1`  in  1  1 = write, 0 = read; qualified by `reqN`.
- `addr0` / `addr1`  in  AW  access address.
- `wdata0` / `wdata1`  in  DW  write data.
- `gnt0` / `gnt1`  out  1  high for the single ACCESS cycle of the granted request.
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse: `rdata` is valid for that requester.
- `rdata`  out  DW  read data; shared by both requesters.
- `ram_wen`  out  1  to `RAM` write enable.
- `ram_addr`  out  AW  to `RAM` address.
- `ram_din`  out  DW  to `RAM` write data.
- `ram_dout`  in  DW  from `RAM` read data, combinational from `ram_addr`.
- `busy`  out  1  high whenever the state is not IDLE.
- `owner`  out  1  index of the most recently granted requester, for display.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- IDLE:
  - `reqN` is sampled only in IDLE.
  - If any request is present, pick a winner, latch its `we/addr/wdata` into internal registers, set `owner`, and go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS, exactly one cycle:
  - `gntN` = 1 for the winner.
  - `ram_addr`/`ram_din` come from the latched fields.
  - `ram_wen` = latched `we`.
  - On a write, go to IDLE.
  - On a read, capture `ram_dout` into `rdata` and go to RESP.
- RESP, exactly one cycle:
  - `rvalidN` = 1 for the owner; `rdata` is held.
  - Go to IDLE.
- Requester inputs may change after the IDLE→ACCESS edge without effect.
- A `reqN` still high when the FSM is back in IDLE is a new request. A requester wanting a single access deasserts `req` in the cycle `gnt` is high.
- Both requesting in IDLE: the winner is chosen per Configuration.
- `ram_wen` is 0 in every state except ACCESS-with-write. The RAM never sees a write outside ACCESS.
- `rdata` holds its last captured value until the next read capture; it is never cleared by writes.

## Timing
- Reset (`clr` = 1 at an edge):
  - state = IDLE.
  - `gnt*`, `rvalid*`, `ram_wen`, `busy`, `owner` = 0.
  - `ram_addr`, `ram_din`, `rdata` = 0.
  - The priority pointer selects requester 0.
- Reset mid-operation aborts the access:
  - No `rvalid` is issued.
  - `ram_wen` is 0 from the cycle after the reset edge.
  - A write already in ACCESS at the reset edge is not guaranteed to be suppressed.
- Write: request seen at edge k → `gnt` and `ram_wen` high in cycle k+1 → RAM written at edge k+2 → IDLE in cycle k+2. Peak rate is one write per 2 cycles.
- Read: request at edge k → `gnt` in k+1 → `rvalid` and `rdata` in k+2 → IDLE in k+3. Peak rate is one read per 3 cycles.
- All outputs are registered or decoded directly from state registers. There is no combinational path from `reqN` to any output.

## Configuration
- `ARB_RR_EN` defined: round-robin.
  - A 1-bit pointer gives priority to the requester not granted last.
  - The pointer updates on every grant.
  - Under continuous contention the grants alternate 0,1,0,1.
- `ARB_RR_EN` undefined: fixed priority.
  - Requester 0 always wins on contention.
  - No pointer register is built.
  - Requester 1 may starve under continuous contention.

## Structure
- Package `ram_bus_pkg`:
  - `state_t` enum {IDLE, ACCESS, RESP}.
  - Constants `RAM_AW` = 4 and `RAM_DW` = 4, used as parameter defaults.
- One sub-module, `arb_pick2`, is natural.
  - Inputs: `req0`, `req1`, `prio`.
  - Outputs: `valid`, `win`.
  - Combinational winner selection, reused by both configurations: `prio` is tied to 0 when `ARB_RR_EN` is undefined.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, `busy` = 0, `ram_wen` never high.
- `req0` write addr 1 data 1, then `req0` read addr 1 → `gnt0` one cycle, `ram_wen` one cycle; read returns `rdata` = 1 with `rvalid0` exactly 2 cycles after the request edge.
- `req1` write addr 0 data 15, then read addr 0, then read addr 1 → `rdata` 15 then 1, only `rvalid1` pulses.
- `req0` and `req1` both held high for 8 grants:
  - With `ARB_RR_EN`: grants alternate 0,1,0,1.
  - Without it: all 8 grants go to requester 0.
- Assert `clr` during RESP of a read → no `rvalid` in the following cycle; state IDLE; `rdata` = 0.
- Change `addr0`/`wdata0` in the ACCESS cycle → RAM is written with the originally latched values; a readback confirms.
